actuator_sequencer: RTL and testbench
=====================================

# actuator_sequencer

Receiving end of the home-automation controller's command interface. Consumes the controller's 3-bit state code and 6-bit one-hot actuator command, and qualifies them with a debounce and a consistency check. Drives the physical actuator enables with a minimum on-time and break-before-make dead time between different actuators. Sits between the automation FSM and the actuator power stage.

## Interface
- STABLE_CYC, 4, consecutive identical request cycles needed to accept a new target (>=1)
- MIN_ON, 8, minimum cycles an actuator stays enabled before it may be switched (>=1)
- DEAD_CYC, 2, all-off cycles inserted between two different actuators (>=1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- code  in  3  controller state code: 0 Idle, 1 FD, 2 RD, 3 FA, 4 W, 5 Heater, 6 Cooler, 7 invalid
- cmd  in  6  controller one-hot actuator command; expected cmd = 0 for code 0, else bit (code-1) only
- act_en  out  6  actuator enables, at most one bit set
- active_code  out  3  code currently driven on act_en (0 when nothing is enabled)
- busy  out  1  high in DEAD, or in ON while the minimum on-time has not elapsed
- err  out  1  sticky mismatch flag

## Operation
- Mismatch: code == 7, or cmd != expected(code). Evaluated combinationally every cycle.
- Request req = code when there is no mismatch.
- Debounce:
  - stab_cnt clears when req differs from the previous cycle's req; otherwise it saturating-increments.
  - Register tgt loads req at the edge that ends the STABLE_CYC-th consecutive identical cycle.
  - tgt holds between updates.
- FSM states OFF, ON, DEAD; on_cnt and dead_cnt are saturating, width $clog2(max+1).
  - OFF: act_en = 0. If tgt != 0, go to ON with active_code = tgt and on_cnt = 0.
  - ON: act_en = onehot(active_code); on_cnt increments to MIN_ON.
    - When on_cnt == MIN_ON and tgt == 0: go to OFF.
    - When on_cnt == MIN_ON and tgt != active_code, tgt != 0: go to DEAD with dead_cnt = 0.
    - If tgt changes and returns to active_code before MIN_ON, there is no transition.
  - DEAD: act_en = 0, active_code = 0. After DEAD_CYC cycles, go to ON with the current tgt, or to OFF if tgt == 0.
- Fault:
  - A mismatch in any cycle sets err.
  - It forces state OFF and tgt = 0, and clears stab_cnt and on_cnt at the next edge, overriding MIN_ON and DEAD.
  - err clears only on rst.
  - After a fault, normal requests are accepted again through the debounce.
- Simultaneous events:
  - Fault has priority over every transition.
  - rst has priority over fault.

## Timing
- Reset values: act_en = 0, active_code = 0, busy = 0, err = 0, state OFF, tgt = 0, all counters 0.
- Outputs are registered. Reset mid-operation drops act_en to 0 in the cycle after the rst edge.
- Latency: a new code first presented in cycle 0 and held gives tgt valid in cycle STABLE_CYC and act_en in cycle STABLE_CYC+1.
- Switch from actuator A to B, once A's MIN_ON has elapsed and tgt = B:
  - act_en = 0 for exactly DEAD_CYC cycles;
  - then B is enabled.
- Fault: mismatch in cycle n gives err = 1 and act_en = 0 in cycle n+1.
- Glitch shorter than STABLE_CYC cycles: no effect on tgt or act_en.

## Structure
- Shared package home_auto_pkg holds:
  - state-code constants IDLE..COOLER and INVALID;
  - function code_to_onehot(code);
  - FSM state encoding OFF/ON/DEAD.
- One sub-module, request_debouncer: inputs code and cmd; outputs tgt and mismatch. It holds stab_cnt and the consistency check.
- The top level holds the FSM, on_cnt and dead_cnt.

## Test plan
- Reset, then code = 5, cmd = 6'b010000 held from cycle 0 -> act_en = 6'b010000 and active_code = 5 from cycle 5. err = 0, busy = 1 for 8 cycles.
- Heater active, MIN_ON not elapsed, code switched to 6 (cmd 6'b100000) -> Heater held until on_cnt = 8. Then act_en = 0 for 2 cycles, then 6'b100000.
- code = 3, cmd = 6'b000100 held for 3 cycles, then code = 0 -> act_en stays 0, tgt stays 0.
- ON with code 1, then code = 2, cmd = 6'b000001 for 1 cycle -> err = 1 and act_en = 0 next cycle. Then a valid code 2 held 4 cycles -> act_en = 6'b000010 while err stays 1.
- code = 7 with cmd = 0 -> err = 1, act_en = 0.
- rst asserted mid-DEAD with a pending switch -> all outputs 0 next cycle. No actuator is enabled until a new 4-cycle stable request.

Source files
------------

// File: rtl/home_auto_pkg.sv
// Shared definitions for the home-automation actuator path: controller
// state codes, the code-to-actuator mapping and the sequencer FSM encoding.
package home_auto_pkg;

  // Controller state codes
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FD      = 3'd1;
  localparam logic [2:0] RD      = 3'd2;
  localparam logic [2:0] FA      = 3'd3;
  localparam logic [2:0] W       = 3'd4;
  localparam logic [2:0] HEATER  = 3'd5;
  localparam logic [2:0] COOLER  = 3'd6;
  localparam logic [2:0] INVALID = 3'd7;

  // Sequencer FSM encoding
  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  // Actuator enable pattern for a state code: Idle and the invalid code
  // drive nothing, every other code drives bit (code-1).
  function automatic logic [5:0] code_to_onehot(input logic [2:0] code);
    logic [5:0] onehot;
    case (code)
      FD:      onehot = 6'b000001;
      RD:      onehot = 6'b000010;
      FA:      onehot = 6'b000100;
      W:       onehot = 6'b001000;
      HEATER:  onehot = 6'b010000;
      COOLER:  onehot = 6'b100000;
      default: onehot = 6'b000000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/request_debouncer.sv
// Qualifies the controller's code/cmd pair: flags any inconsistency and only
// promotes a request to the target once it has been held STABLE_CYC cycles.
module request_debouncer
  import home_auto_pkg::*;
#(
  parameter int STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code,
  input  logic [5:0] cmd,
  output logic [2:0] tgt,
  output logic       mismatch
);

  localparam int              ST_W    = $clog2(STABLE_CYC + 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STABLE_CYC - 1);

  logic [2:0]      req;
  logic [2:0]      prev_req_q, prev_req_d;
  logic [2:0]      tgt_q, tgt_d;
  logic [ST_W-1:0] stab_cnt_q, stab_cnt_d;

  // Consistency check; an inconsistent cycle is tracked as the INVALID request
  // so the first good cycle after a fault always restarts the stability run.
  always_comb begin
    mismatch = (code == INVALID) || (cmd != code_to_onehot(code));
    req      = mismatch ? INVALID : code;
  end

  // Stability counter and target update.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    prev_req_d = req;
    stab_cnt_d = stab_cnt_q;
    tgt_d      = tgt_q;
    if (mismatch) begin
      stab_cnt_d = '0;
      tgt_d      = IDLE;
    end else begin
      if (req != prev_req_q) begin
        stab_cnt_d = '0;
      end else if (stab_cnt_q != ST_LAST) begin
        stab_cnt_d = stab_cnt_q + ST_W'(1);
      end
      // stab_cnt_d == ST_LAST means this is at least the STABLE_CYC-th
      // consecutive identical cycle; reloading a saturated run is harmless.
      if (stab_cnt_d == ST_LAST) begin
        tgt_d = req;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every flop
    // samples the pre-edge value, independent of statement order.
    if (rst) begin
      prev_req_q <= IDLE;
      stab_cnt_q <= '0;
      tgt_q      <= IDLE;
    end else begin
      prev_req_q <= prev_req_d;
      stab_cnt_q <= stab_cnt_d;
      tgt_q      <= tgt_d;
    end
  end

  assign tgt = tgt_q;

endmodule

// File: rtl/actuator_sequencer.sv
// Drives the actuator power stage from the debounced target: one actuator at
// a time, a minimum on-time before switching, and an all-off dead time
// between two different actuators. Any command inconsistency drops all
// enables immediately and latches err until reset.
module actuator_sequencer
  import home_auto_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int MIN_ON     = 8,
  parameter int DEAD_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code,
  input  logic [5:0] cmd,
  output logic [5:0] act_en,
  output logic [2:0] active_code,
  output logic       busy,
  output logic       err
);

  localparam int                ON_W      = $clog2(MIN_ON + 1);
  localparam int                DEAD_W    = $clog2(DEAD_CYC + 1);
  localparam logic [ON_W-1:0]   ON_MAX    = ON_W'(MIN_ON);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);

  logic [2:0]        tgt;
  logic              mismatch;
  logic [1:0]        state_q, state_d;
  logic [2:0]        active_code_q, active_code_d;
  logic [ON_W-1:0]   on_cnt_q, on_cnt_d;
  logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
  logic [5:0]        act_en_q, act_en_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  request_debouncer #(
    .STABLE_CYC(STABLE_CYC)
  ) u_request_debouncer (
    .clk     (clk),
    .rst     (rst),
    .code    (code),
    .cmd     (cmd),
    .tgt     (tgt),
    .mismatch(mismatch)
  );

  // Sequencer FSM with fault override; outputs are computed from the next
  // state so they can be registered without adding latency.
  always_comb begin
    state_d       = state_q;
    active_code_d = active_code_q;
    on_cnt_d      = on_cnt_q;
    dead_cnt_d    = dead_cnt_q;

    case (state_q)
      S_OFF: begin
        active_code_d = IDLE;
        if (tgt != IDLE) begin
          state_d       = S_ON;
          active_code_d = tgt;
          on_cnt_d      = '0;
        end
      end
      S_ON: begin
        // A target that changes and returns before MIN_ON is simply ignored.
        if (on_cnt_q != ON_MAX) begin
          on_cnt_d = on_cnt_q + ON_W'(1);
        end else if (tgt == IDLE) begin
          state_d       = S_OFF;
          active_code_d = IDLE;
        end else if (tgt != active_code_q) begin
          state_d       = S_DEAD;
          active_code_d = IDLE;
          dead_cnt_d    = '0;
        end
      end
      S_DEAD: begin
        active_code_d = IDLE;
        if (dead_cnt_q != DEAD_LAST) begin
          dead_cnt_d = dead_cnt_q + DEAD_W'(1);
        end else if (tgt == IDLE) begin
          state_d = S_OFF;
        end else begin
          state_d       = S_ON;
          active_code_d = tgt;
          on_cnt_d      = '0;
        end
      end
      default: begin
        state_d       = S_OFF;
        active_code_d = IDLE;
      end
    endcase

    // A mismatch wins over every transition, including MIN_ON and DEAD.
    if (mismatch) begin
      state_d       = S_OFF;
      active_code_d = IDLE;
      on_cnt_d      = '0;
      dead_cnt_d    = '0;
    end

    act_en_d = code_to_onehot(active_code_d);
    busy_d   = (state_d == S_DEAD) || ((state_d == S_ON) && (on_cnt_d != ON_MAX));
    err_d    = err_q | mismatch;
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_OFF;
      active_code_q <= IDLE;
      on_cnt_q      <= '0;
      dead_cnt_q    <= '0;
      act_en_q      <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_code_q <= active_code_d;
      on_cnt_q      <= on_cnt_d;
      dead_cnt_q    <= dead_cnt_d;
      act_en_q      <= act_en_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign act_en      = act_en_q;
  assign active_code = active_code_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_actuator_sequencer.sv
// Scoreboard bench for actuator_sequencer: the stimulus thread queues the
// expected {act_en, active_code, busy, err} for chosen cycles, and a monitor
// on the falling edge pops and compares whenever a queued cycle comes up.
module tb_actuator_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] code;
  logic [5:0] cmd;
  logic [5:0] act_en;
  logic [2:0] active_code;
  logic       busy;
  logic       err;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int base;
  int b2;

  typedef struct {
    int          cyc;
    logic [10:0] resp;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  actuator_sequencer #(
    .STABLE_CYC(4),
    .MIN_ON    (8),
    .DEAD_CYC  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .code       (code),
    .cmd        (cmd),
    .act_en     (act_en),
    .active_code(active_code),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Cycle k spans posedge k to posedge k+1.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got act_en=%b code=%0d busy=%b err=%b, expected act_en=%b code=%0d busy=%b err=%b",
               name, cyc, got[10:5], got[4:2], got[1], got[0],
               want[10:5], want[4:2], want[1], want[0]);
    end
  endtask

  task automatic expect_at(input int c, input string nm, input logic [5:0] a,
                           input logic [2:0] ac, input logic b, input logic e);
    exp_t x;
    x.cyc  = c;
    x.resp = {a, ac, b, e};
    x.name = nm;
    sb.push_back(x);
  endtask

  // Present code/cmd for n cycles, returning just after the next cycle starts.
  task automatic drive(input logic [2:0] c, input logic [5:0] m, input int n);
    code = c;
    cmd  = m;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation when its cycle is reached.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed, now cycle %0d", mon_e.name, mon_e.cyc, cyc);
      end else begin
        check(mon_e.name, {act_en, active_code, busy, err}, mon_e.resp);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    code = 3'd0;
    cmd  = 6'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_at(cyc, "reset_state", 6'b0, 3'd0, 1'b0, 1'b0);
    rst  = 1'b0;
    base = cyc;

    // Heater accept, heater->cooler switch, return to idle, short glitch.
    expect_at(base + 4,  "pre_enable",         6'b000000, 3'd0, 1'b0, 1'b0);
    expect_at(base + 5,  "heater_on",          6'b010000, 3'd5, 1'b1, 1'b0);
    expect_at(base + 11, "heater_hold_tgt6",   6'b010000, 3'd5, 1'b1, 1'b0);
    expect_at(base + 12, "heater_last_busy",   6'b010000, 3'd5, 1'b1, 1'b0);
    expect_at(base + 13, "heater_min_elapsed", 6'b010000, 3'd5, 1'b0, 1'b0);
    expect_at(base + 14, "dead_1",             6'b000000, 3'd0, 1'b1, 1'b0);
    expect_at(base + 15, "dead_2",             6'b000000, 3'd0, 1'b1, 1'b0);
    expect_at(base + 16, "cooler_on",          6'b100000, 3'd6, 1'b1, 1'b0);
    expect_at(base + 23, "cooler_hold",        6'b100000, 3'd6, 1'b1, 1'b0);
    expect_at(base + 24, "cooler_min_elapsed", 6'b100000, 3'd6, 1'b0, 1'b0);
    expect_at(base + 25, "cooler_off",         6'b000000, 3'd0, 1'b0, 1'b0);
    expect_at(base + 29, "glitch_during",      6'b000000, 3'd0, 1'b0, 1'b0);
    expect_at(base + 31, "glitch_after",       6'b000000, 3'd0, 1'b0, 1'b0);
    expect_at(base + 34, "glitch_settled",     6'b000000, 3'd0, 1'b0, 1'b0);

    drive(3'd5, 6'b010000, 7);   // base+0  .. base+6
    drive(3'd6, 6'b100000, 13);  // base+7  .. base+19
    drive(3'd0, 6'b000000, 7);   // base+20 .. base+26
    drive(3'd3, 6'b000100, 3);   // base+27 .. base+29
    drive(3'd0, 6'b000000, 5);   // base+30 .. base+34

    b2 = cyc;
    // Fault during ON, recovery with err sticky, reset mid-DEAD, invalid code.
    expect_at(b2 + 5,  "fd_on",              6'b000001, 3'd1, 1'b1, 1'b0);
    expect_at(b2 + 7,  "fd_before_fault",    6'b000001, 3'd1, 1'b1, 1'b0);
    expect_at(b2 + 8,  "mismatch_fault",     6'b000000, 3'd0, 1'b0, 1'b1);
    expect_at(b2 + 12, "post_fault_wait",    6'b000000, 3'd0, 1'b0, 1'b1);
    expect_at(b2 + 13, "rd_after_fault",     6'b000010, 3'd2, 1'b1, 1'b1);
    expect_at(b2 + 21, "rd_min_elapsed",     6'b000010, 3'd2, 1'b0, 1'b1);
    expect_at(b2 + 22, "dead_before_rst",    6'b000000, 3'd0, 1'b1, 1'b1);
    expect_at(b2 + 23, "rst_mid_dead",       6'b000000, 3'd0, 1'b0, 1'b0);
    expect_at(b2 + 24, "no_pending_switch",  6'b000000, 3'd0, 1'b0, 1'b0);
    expect_at(b2 + 27, "debounce_after_rst", 6'b000000, 3'd0, 1'b0, 1'b0);
    expect_at(b2 + 28, "w_on_after_rst",     6'b001000, 3'd4, 1'b1, 1'b0);
    expect_at(b2 + 31, "invalid_code",       6'b000000, 3'd0, 1'b0, 1'b1);
    expect_at(b2 + 33, "err_sticky",         6'b000000, 3'd0, 1'b0, 1'b1);

    drive(3'd1, 6'b000001, 7);   // b2+0  .. b2+6
    drive(3'd2, 6'b000001, 1);   // b2+7  inconsistent cmd
    drive(3'd2, 6'b000010, 7);   // b2+8  .. b2+14
    drive(3'd4, 6'b001000, 7);   // b2+15 .. b2+21
    rst = 1'b1;
    drive(3'd4, 6'b001000, 1);   // b2+22 reset in DEAD
    rst = 1'b0;
    drive(3'd4, 6'b001000, 7);   // b2+23 .. b2+29
    drive(3'd7, 6'b000000, 1);   // b2+30 invalid code
    drive(3'd0, 6'b000000, 5);   // b2+31 .. b2+35

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expectations still queued, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
